// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared defaults and constant helpers for the CIC interpolator
package cic_pkg;

  localparam int STAGES_DEF = 5;
  localparam int IBITS_DEF  = 20;
  localparam int OBITS_DEF  = 16;
  localparam int RMAX_DEF   = 320;
  localparam int CNTW_DEF   = 9;
  localparam int GBITS_DEF  = 34;
  localparam int GSW        = 6;

  function automatic int clog2(input int value);
    int res;
    int tmp;
    res = 0;
    tmp = value - 1;
    while (tmp > 0) begin
      res = res + 1;
      tmp = tmp >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_interp_var_if.sv
// rtl/cic_interp_var_if.sv - sample/strobe bundle between the interpolator and its user
interface cic_interp_var_if
  import cic_pkg::*;
#(
  parameter int IBITS = IBITS_DEF,
  parameter int OBITS = OBITS_DEF,
  parameter int CNTW  = CNTW_DEF
);
  logic                    clock_en;
  logic [CNTW-1:0]         rate;
  logic [GSW-1:0]          gain_shift;
  logic                    in_valid;
  logic signed [IBITS-1:0] x_real;
  logic signed [IBITS-1:0] x_imag;
  logic                    req;
  logic                    underrun;
  logic signed [OBITS-1:0] y_real;
  logic signed [OBITS-1:0] y_imag;
  logic                    out_valid;

  modport master (
    output clock_en, rate, gain_shift, in_valid, x_real, x_imag,
    input  req, underrun, y_real, y_imag, out_valid
  );

  modport slave (
    input  clock_en, rate, gain_shift, in_valid, x_real, x_imag,
    output req, underrun, y_real, y_imag, out_valid
  );
endinterface

// File: rtl/cic_interp_var_ch.sv
// rtl/cic_interp_var_ch.sv - one CIC channel: input-rate combs, output-rate integrators,
// round-half-up and saturate to OBITS.
module cic_interp_var_ch
  import cic_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int IBITS  = IBITS_DEF,
  parameter int OBITS  = OBITS_DEF,
  parameter int GBITS  = GBITS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    load,
  input  logic                    flush,
  input  logic signed [IBITS-1:0] x,
  input  logic [GSW-1:0]          gain_shift,
  output logic signed [OBITS-1:0] y
);
  localparam int CBITS = IBITS + GBITS;
  localparam int SHW   = clog2(IBITS - OBITS + 64);
  localparam logic signed [CBITS:0] OMAX = (CBITS+1)'((64'sd1 <<< (OBITS - 1)) - 64'sd1);
  localparam logic signed [CBITS:0] OMIN = ~OMAX;

  logic signed [CBITS-1:0] dly   [STAGES];
  logic signed [CBITS-1:0] tap   [STAGES];
  logic signed [CBITS-1:0] integ [STAGES];
  logic signed [CBITS-1:0] comb_out, feed, last;
  logic [SHW-1:0]          sh;
  logic signed [CBITS:0]   rnd, wide, shifted;
  logic signed [OBITS-1:0] sat;

  // A rate-change flush treats every delay as already cleared for this load.
  always_comb begin
    logic signed [CBITS-1:0] acc;
    acc = {{GBITS{x[IBITS-1]}}, x};
    for (int k = 0; k < STAGES; k++) begin
      tap[k] = acc;
      acc    = acc - (flush ? '0 : dly[k]);
    end
    comb_out = acc;
  end

  assign feed = load ? comb_out : '0;
  assign last = flush ? '0 : integ[STAGES-1];

  // One guard bit above CBITS keeps the rounding add from wrapping.
  always_comb begin
    sh  = SHW'(IBITS - OBITS) + SHW'(gain_shift);
    rnd = '0;
    if (sh != '0) rnd = (CBITS+1)'(1) <<< (sh - SHW'(1));
    wide    = {last[CBITS-1], last} + rnd;
    shifted = wide >>> sh;
    if (shifted > OMAX)      sat = OMAX[OBITS-1:0];
    else if (shifted < OMIN) sat = OMIN[OBITS-1:0];
    else                     sat = shifted[OBITS-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        dly[k]   <= '0;
        integ[k] <= '0;
      end
      y <= '0;
    end else if (en) begin
      integ[0] <= (flush ? '0 : integ[0]) + feed;
      for (int k = 1; k < STAGES; k++)
        integ[k] <= flush ? '0 : integ[k] + integ[k-1];
      if (load)
        for (int k = 0; k < STAGES; k++) dly[k] <= tap[k];
      y <= sat;
    end
  end

endmodule

// File: rtl/cic_interp_var.sv
// rtl/cic_interp_var.sv - variable-rate complex CIC interpolator; owns the rate counter,
// request/underrun strobes and the effective rate register.
module cic_interp_var
  import cic_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int IBITS  = IBITS_DEF,
  parameter int OBITS  = OBITS_DEF,
  parameter int RMAX   = RMAX_DEF,
  parameter int CNTW   = CNTW_DEF,
  parameter int GBITS  = GBITS_DEF
) (
  input logic              clock,
  input logic              reset,
  cic_interp_var_if.slave  bus
);
  logic [CNTW-1:0]         counter, rate_l, rate_c;
  logic                    load, flush;
  logic signed [IBITS-1:0] smp_r, smp_i;

  always_comb begin
    if (bus.rate < CNTW'(2))         rate_c = CNTW'(2);
    else if (bus.rate > CNTW'(RMAX)) rate_c = CNTW'(RMAX);
    else                             rate_c = bus.rate;
  end

  // Rate changes only take effect on a load event, where they also flush the datapath.
  assign load  = bus.clock_en && (counter == rate_l - CNTW'(1));
  assign flush = load && (rate_c != rate_l);
  assign smp_r = bus.in_valid ? bus.x_real : '0;
  assign smp_i = bus.in_valid ? bus.x_imag : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter       <= '0;
      rate_l        <= CNTW'(2);
      bus.req       <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.req       <= load;
      bus.underrun  <= load && !bus.in_valid;
      bus.out_valid <= bus.clock_en;
      if (load) begin
        counter <= '0;
        rate_l  <= rate_c;
      end else if (bus.clock_en) begin
        counter <= counter + CNTW'(1);
      end
    end
  end

  cic_interp_var_ch #(.STAGES(STAGES), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)) u_ch_real (
    .clock(clock), .reset(reset), .en(bus.clock_en), .load(load), .flush(flush),
    .x(smp_r), .gain_shift(bus.gain_shift), .y(bus.y_real)
  );

  cic_interp_var_ch #(.STAGES(STAGES), .IBITS(IBITS), .OBITS(OBITS), .GBITS(GBITS)) u_ch_imag (
    .clock(clock), .reset(reset), .en(bus.clock_en), .load(load), .flush(flush),
    .x(smp_i), .gain_shift(bus.gain_shift), .y(bus.y_imag)
  );

endmodule

// File: doc/cic_interp_var.md
CIC_INTERP_VAR -- requirements
Module: cic_interp_var

Interface
REQ-001 SHALL have parameter STAGES, default 5, number of comb/integrator stages (1..8).
REQ-002 SHALL have parameter IBITS, default 20, input sample width.
REQ-003 SHALL have parameter OBITS, default 16, output sample width (OBITS <= IBITS).
REQ-004 SHALL have parameter RMAX, default 320, maximum interpolation rate.
REQ-005 SHALL have parameter CNTW, default 9, rate/counter width (2^CNTW > RMAX).
REQ-006 SHALL have parameter GBITS, default 34, growth bits; CBITS = IBITS + GBITS.
REQ-007 SHALL have port clock, input, 1, the single clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port clock_en, input, 1, output-rate strobe.
REQ-010 SHALL have port rate, input, CNTW, requested interpolation rate.
REQ-011 SHALL have port gain_shift, input, 6, extra right shift (0..GBITS).
REQ-012 SHALL have port in_valid, input, 1, input sample present.
REQ-013 SHALL have ports x_real / x_imag, input, IBITS each, signed input samples.
REQ-014 SHALL have port req, output, 1, one-clock request for next input.
REQ-015 SHALL have port underrun, output, 1, one-clock pulse on missing input.
REQ-016 SHALL have ports y_real / y_imag, output, OBITS each, signed output samples.
REQ-017 SHALL have port out_valid, output, 1, one-clock strobe qualifying y_real / y_imag.

Function
REQ-018 SHALL effective rate rate_l = clamp(rate, 2, RMAX); rate_l is registered.
REQ-019 SHALL count clock_en cycles 0..rate_l-1 in counter; the clock_en cycle with counter == rate_l-1 is a load event; counter wraps to 0.
REQ-020 SHALL, at a load event, capture sign-extended x_real / x_imag into comb stage 0 if in_valid=1, else capture 0 and pulse underrun on the next clock.
REQ-021 SHALL assert req for exactly one clock, the clock after each load event; req=0 at all other times, including clock_en=0.
REQ-022 SHALL advance the STAGES comb stages (x[k] = x[k-1] - x[k-1] delayed) only at load events, using CBITS two's-complement wrap arithmetic.
REQ-023 SHALL feed the last comb output to the integrator chain at load events and 0 on other clock_en cycles (zero stuffing).
REQ-024 SHALL advance the STAGES integrators on every clock_en cycle, with CBITS wrap arithmetic (no saturation internally).
REQ-025 SHALL compute out = saturate_OBITS((yN + 2^(SH-1)) >>> SH), where SH = IBITS - OBITS + gain_shift, with round-half-up and saturation to [-2^(OBITS-1), 2^(OBITS-1)-1].
REQ-026 SHALL register y_real, y_imag and out_valid one clock after each clock_en cycle; out_valid=0 otherwise.
REQ-027 SHALL, at a load event where clamp(rate) != rate_l:
- update rate_l;
- clear all comb, delay and integrator registers;
- then load the current input as in REQ-020.
REQ-028 SHALL treat a rate change between load events as invisible until the next load event.
REQ-029 SHALL, when clock_en=0, hold all state; in that case req, underrun and out_valid are 0.

Reset
REQ-030 SHALL, while reset=1, force all of the following to 0: counter, all datapath registers, req, underrun, out_valid, y_real, y_imag.
REQ-031 SHALL, while reset=1, force rate_l to 2.
REQ-032 SHALL, on reset release, make the first load event occur on the second clock_en cycle, then continue per REQ-018/REQ-019.
REQ-033 SHALL take effect immediately on reset asserted mid-operation, discarding all in-flight samples.

Structure
REQ-034 SHALL place the default parameter values and a constant clog2 function in shared package cic_pkg.
REQ-035 SHALL implement one channel (comb + integrator + round/saturate) as sub-module cic_interp_var_ch, instantiated twice (real, imag); control (counter, rate_l, req, underrun) lives in the top.

Verification
REQ-036 SHALL cover DC: rate=4, gain_shift=8, x_real=1000 constant, in_valid=1 -> steady-state y_real=63 (256000/4096 rounded half-up).
REQ-037 SHALL cover impulse: rate=2, gain_shift=0, a single x_real=4096 then zeros -> nonzero outputs exactly 256,1280,2560,2560,1280,256 on consecutive out_valid.
REQ-038 SHALL cover saturation: rate=320, gain_shift=0, x_real=+524287 then -524288 held -> y_real=32767 then -32768, with no wrap glitch.
REQ-039 SHALL cover underrun: in_valid=0 at one load event -> underrun high one clock, and that sample is treated as 0 (output matches the model).
REQ-040 SHALL cover rate change: rate 4->8 mid-stream -> state flushed at the next load event, then req spacing = 8 clock_en cycles.
REQ-041 SHALL cover reset mid-stream: reset asserted -> same clock all outputs 0; after release the first req occurs as per REQ-032.
